matvec_result_requant: RTL and testbench



---
 rtl/matvec_result_requant.sv | 141 ++++++++++++++
 tb/tb_matvec_result_requant.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_result_requant.sv
// Requantizer behind matvec3_part2: rounds, shifts and saturates 28-bit results to 14 bits,
// tags vector ends, and buffers them in a first-word-fall-through FIFO.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data signed IN_W-bit sample
//   out_valid/out_ready   downstream handshake, out_data signed OUT_W-bit result
//   out_last              head is element K-1 of its vector
//   sat_count             saturated samples since reset, sticks at 16'hFFFF
//
// Optional: define MATVEC_REQUANT_RELU_EN to clamp negative results to zero.
module matvec_result_requant #(
    parameter int K     = 3,
    parameter int IN_W  = 28,
    parameter int OUT_W = 14,
    parameter int SHIFT = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      sat_count
);

    localparam int W1 = IN_W + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int EW = (K > 1) ? $clog2(K) : 1;

    // Half an output LSB; shifting 1 up then back down yields 0 when SHIFT == 0.
    localparam logic signed [W1-1:0] RND  = (W1'(1) << SHIFT) >> 1;
    localparam logic signed [W1-1:0] QMAX =
        {{(W1-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W1-1:0] QMIN = ~QMAX;

    logic signed [W1-1:0] t;
    logic signed [W1-1:0] q;
    logic [OUT_W-1:0]     rq;
    logic                 rsat;

    logic                 in_xfer;
    logic                 pop;
    logic                 last;
    logic [EW-1:0]        elem_idx;

    logic                 s1_valid;
    logic [OUT_W-1:0]     s1_data;
    logic                 s1_last;

    logic [OUT_W:0]       mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [AW+1:0]        occ;
    logic [OUT_W:0]       head;

    always_comb begin
        t    = $signed({in_data[IN_W-1], in_data}) + RND;
        q    = t >>> SHIFT;
        rq   = q[OUT_W-1:0];
        rsat = 1'b0;
        if (q > QMAX) begin
            rq   = QMAX[OUT_W-1:0];
            rsat = 1'b1;
        end else if (q < QMIN) begin
            rq   = QMIN[OUT_W-1:0];
            rsat = 1'b1;
        end
`ifdef MATVEC_REQUANT_RELU_EN
        // Negative results become zero and are not counted as saturation.
        if (q[W1-1]) begin
            rq   = '0;
            rsat = 1'b0;
        end
`endif
    end

    // Occupancy includes the sample in s1, so s1 always has a free slot to land in.
    assign occ      = {1'b0, count} + {{(AW+1){1'b0}}, s1_valid};
    assign in_ready = occ < (AW+2)'(DEPTH);
    assign in_xfer  = in_valid & in_ready;
    assign last     = elem_idx == EW'(K - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_last   <= 1'b0;
            elem_idx  <= '0;
            sat_count <= '0;
        end else begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_data  <= rq;
                s1_last  <= last;
                elem_idx <= last ? '0 : elem_idx + EW'(1);
                if (rsat && sat_count != 16'hFFFF) begin
                    sat_count <= sat_count + 16'd1;
                end
            end
        end
    end

    assign out_valid = count != '0;
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[OUT_W-1:0] : '0;
    assign out_last  = out_valid & head[OUT_W];

    always_ff @(posedge clk) begin
        if (!reset && s1_valid) begin
            mem[wr_ptr] <= {s1_last, s1_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (s1_valid) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({s1_valid, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_result_requant.sv
// Bench for matvec_result_requant: directed scenarios plus a randomized
// valid/ready stream, all outputs checked against a queued reference model.
module tb_matvec_result_requant;

    localparam int K     = 3;
    localparam int IN_W  = 28;
    localparam int OUT_W = 14;
    localparam int SHIFT = 6;
    localparam int DEPTH = 8;
    localparam int N_RAND = 30000;

    typedef logic [OUT_W:0] ent_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic [15:0]      sat_count;

    int errors = 0;
    int checks = 0;

    ent_t        exp_q[$];
    ent_t        obs_q[$];
    int          m_idx = 0;
    logic [15:0] m_sat = '0;
    int          out_cnt = 0;

    always #5 clk = ~clk;

    matvec_result_requant #(
        .K(K), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .sat_count(sat_count)
    );

    function automatic ent_t model(input logic [IN_W-1:0] d, input bit lst,
                                   output bit sat);
        longint p, t, q, omax;
        p    = longint'(1) << SHIFT;
        omax = (longint'(1) << (OUT_W - 1)) - 1;
        t    = longint'($signed(d)) + p / 2;
        q    = t / p;
        if ((t % p) != 0 && t < 0) q = q - 1;
        sat = 1'b0;
        if (q > omax) begin
            q = omax;
            sat = 1'b1;
        end else if (q < -omax - 1) begin
            q = -omax - 1;
            sat = 1'b1;
        end
`ifdef MATVEC_REQUANT_RELU_EN
        if (q < 0) begin
            q = 0;
            sat = 1'b0;
        end
`endif
        return {lst, OUT_W'(q)};
    endfunction

    function automatic int odata(input ent_t e);
        return int'($signed(e[OUT_W-1:0]));
    endfunction

    // Monitor: handshakes are stable at the falling edge and complete on the next rising edge.
    always @(negedge clk) begin
        ent_t e;
        bit   s;
        if (reset) begin
            exp_q.delete();
            m_idx = 0;
            m_sat = '0;
        end else begin
            if (out_valid && out_ready) begin
                out_cnt++;
                obs_q.push_back({out_last, out_data});
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got=%0d last=%0b",
                             $signed(out_data), out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        errors++;
                        $display("FAIL out_data got=%0d/%0b want=%0d/%0b",
                                 $signed(out_data), out_last,
                                 odata(e), e[OUT_W]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, m_idx == K - 1, s));
                if (s && m_sat != 16'hFFFF) m_sat++;
                m_idx = (m_idx == K - 1) ? 0 : m_idx + 1;
            end
        end
    end

    task automatic send(input logic [IN_W-1:0] d, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_data = d;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=in_ready_low want=accept");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data = 'x;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_out_data got=%h want=0", out_data);
        end
        if (out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_last got=%b want=0", out_last);
        end
        if (sat_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_sat_count got=%0d want=0", sat_count);
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_rounding();
        int vin[5]  = '{64, 32, 31, -32, -33};
        int vexp[5] = '{1, 1, 0, 0, -1};
        bit lexp[5] = '{0, 0, 1, 0, 0};
        int w;
        reset_dut();
        out_ready = 1'b1;
        obs_q.delete();
        for (int i = 0; i < 5; i++) send(IN_W'(vin[i]), w);
        idle();
        drain();
        checks++;
        if (obs_q.size() != 5) begin
            errors++;
            $display("FAIL round_count got=%0d want=5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks += 2;
                if (odata(obs_q[i]) !== vexp[i]) begin
                    errors++;
                    $display("FAIL round_data[%0d] got=%0d want=%0d",
                             i, odata(obs_q[i]), vexp[i]);
                end
                if (obs_q[i][OUT_W] !== lexp[i]) begin
                    errors++;
                    $display("FAIL round_last[%0d] got=%b want=%b",
                             i, obs_q[i][OUT_W], lexp[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int w;
`ifdef MATVEC_REQUANT_RELU_EN
        int want_lo  = 0;
        int want_sat = 1;
`else
        int want_lo  = -8192;
        int want_sat = 2;
`endif
        reset_dut();
        out_ready = 1'b1;
        obs_q.delete();
        send(28'h7FFFFFF, w);
        send(28'h8000000, w);
        idle();
        drain();
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL sat_count_out got=%0d want=2", obs_q.size());
        end else begin
            checks += 2;
            if (odata(obs_q[0]) !== 8191) begin
                errors++;
                $display("FAIL sat_hi got=%0d want=8191", odata(obs_q[0]));
            end
            if (odata(obs_q[1]) !== want_lo) begin
                errors++;
                $display("FAIL sat_lo got=%0d want=%0d", odata(obs_q[1]), want_lo);
            end
        end
        checks++;
        if (sat_count !== 16'(want_sat)) begin
            errors++;
            $display("FAIL sat_counter got=%0d want=%0d", sat_count, want_sat);
        end
    endtask

    task automatic test_full_empty();
        int acc;
        acc = 0;
        reset_dut();
        out_ready = 1'b0;
        obs_q.delete();
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data = IN_W'(i * 64);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        idle();
        @(negedge clk);
        checks += 2;
        if (acc != DEPTH) begin
            errors++;
            $display("FAIL full_accepted got=%0d want=%0d", acc, DEPTH);
        end
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_in_ready got=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pop_pending_in_ready got=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reassert_in_ready got=%b want=1", in_ready);
        end
        @(posedge clk);
        #1;
        drain();
        checks++;
        if (obs_q.size() != DEPTH) begin
            errors++;
            $display("FAIL full_out_count got=%0d want=%0d", obs_q.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks += 2;
                if (odata(obs_q[i]) !== i) begin
                    errors++;
                    $display("FAIL full_order[%0d] got=%0d want=%0d",
                             i, odata(obs_q[i]), i);
                end
                if (obs_q[i][OUT_W] !== (i == 2 || i == 5)) begin
                    errors++;
                    $display("FAIL full_last[%0d] got=%b want=%b",
                             i, obs_q[i][OUT_W], (i == 2 || i == 5));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int stall;
        stall = 0;
        reset_dut();
        out_ready = 1'b0;
        obs_q.delete();
        for (int k = 0; k < DEPTH; k++) send(IN_W'(k * 64), w);
        out_ready = 1'b1;
        for (int k = DEPTH; k < 100; k++) begin
            send(IN_W'(k * 64), w);
            stall += w;
        end
        idle();
        drain();
        checks += 2;
        if (stall > 2) begin
            errors++;
            $display("FAIL b2b_stall_cycles got=%0d want<=2", stall);
        end
        if (obs_q.size() != 100) begin
            errors++;
            $display("FAIL b2b_count got=%0d want=100", obs_q.size());
        end else begin
            for (int i = 0; i < 100; i++) begin
                checks++;
                if (odata(obs_q[i]) !== i || obs_q[i][OUT_W] !== (i % 3 == 2)) begin
                    errors++;
                    $display("FAIL b2b_seq[%0d] got=%0d/%b want=%0d/%b", i,
                             odata(obs_q[i]), obs_q[i][OUT_W], i, (i % 3 == 2));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        reset_dut();
        out_ready = 1'b0;
        send(28'h7FFFFFF, w);
        send(IN_W'(64), w);
        idle();
        @(negedge clk);
        checks++;
        if (sat_count !== 16'd1) begin
            errors++;
            $display("FAIL mid_sat_before got=%0d want=1", sat_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_out_valid got=%b want=0", out_valid);
        end
        if (sat_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_sat_after got=%0d want=0", sat_count);
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_ready got=%b want=1", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        obs_q.delete();
        for (int i = 1; i <= 3; i++) send(IN_W'(i * 64), w);
        idle();
        drain();
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL mid_count got=%0d want=3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i][OUT_W] !== (i == 2)) begin
                    errors++;
                    $display("FAIL mid_last[%0d] got=%b want=%b",
                             i, obs_q[i][OUT_W], (i == 2));
                end
            end
        end
    endtask

    task automatic test_random();
        int sent;
        int cyc;
        int base;
        logic [3:0]  r;
        logic signed [19:0] s;
        sent = 0;
        cyc = 0;
        reset_dut();
        base = out_cnt;
        while (sent < N_RAND && cyc < 90000) begin
            r = 4'($urandom);
            s = 20'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            if (r < 4) in_data = IN_W'($urandom);
            else if (r < 6) in_data = IN_W'(int'(s[12:0]) * 64 + (r[0] ? 32 : -32));
            else in_data = IN_W'(s);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        idle();
        drain();
        checks += 3;
        if (sent != N_RAND) begin
            errors++;
            $display("FAIL rand_sent got=%0d want=%0d", sent, N_RAND);
        end
        if (out_cnt - base != sent) begin
            errors++;
            $display("FAIL rand_received got=%0d want=%0d", out_cnt - base, sent);
        end
        if (sat_count !== m_sat) begin
            errors++;
            $display("FAIL rand_sat_count got=%0d want=%0d", sat_count, m_sat);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_full_empty();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
